pipe_mult: RTL
==============

PIPE_MULT -- requirements
Module: pipe_mult

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter NUM_STAGE, default 4, pipeline depth; 2*XLEN divisible by NUM_STAGE, otherwise elaboration error.
REQ-003 SHALL have parameter TAG_W, default 5, width of the pass-through tag.
REQ-004 SHALL have port: clock  input  1  clock, rising edge.
REQ-005 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port: in_valid  input  1  request present.
REQ-007 SHALL have port: in_ready  output  1  request accepted when in_valid && in_ready.
REQ-008 SHALL have port: func  input  2  mul_func_t: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU.
REQ-009 SHALL have port: rs1  input  XLEN  multiplicand.
REQ-010 SHALL have port: rs2  input  XLEN  multiplier.
REQ-011 SHALL have port: in_tag  input  TAG_W  request tag.
REQ-012 SHALL have port: flush  input  1  kill all in-flight ops (only when PIPE_MULT_FLUSH_EN is defined).
REQ-013 SHALL have port: out_valid  output  1  result present.
REQ-014 SHALL have port: out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-015 SHALL have port: result  output  XLEN  selected product half.
REQ-016 SHALL have port: out_tag  output  TAG_W  tag of the request producing result.
REQ-017 SHALL have port: busy  output  1  any stage holds a valid op.

Function
REQ-018 SHALL sign-extend rs1 to 2*XLEN for MULH/MULHSU and rs2 for MULH only; otherwise zero-extend.
REQ-019 SHALL have each stage add (next NUM_BITS=2*XLEN/NUM_STAGE multiplier bits) x (shifted multiplicand) to the running product; the full 2*XLEN product is exact modulo 2^(2*XLEN).
REQ-020 SHALL output product[XLEN-1:0] for MUL and product[2*XLEN-1:XLEN] for the other three functions.
REQ-021 SHALL keep a valid bit per stage; stage k advances when stage k+1 is empty or advancing; the last stage drains on out_ready.
REQ-022 SHALL drive in_ready = !valid[0] || stage 0 advancing; bubbles collapse independently of each other.
REQ-023 SHALL assert out_valid exactly NUM_STAGE cycles after acceptance when there is no backpressure; throughput one op per cycle.
REQ-024 SHALL hold result/out_tag stable while out_valid && !out_ready; no op lost or duplicated; order preserved.
REQ-025 SHALL drive busy as OR of all stage valid bits.

Reset
REQ-026 SHALL, on reset, clear all valid bits and all stage data registers to 0: out_valid=0, result=0, out_tag=0, busy=0, in_ready=1 in the next cycle.
REQ-027 SHALL have reset take priority over acceptance, advance and flush; ops in flight at reset are discarded.

Configuration
REQ-028 SHALL, with PIPE_MULT_FLUSH_EN defined, have flush clear all valid bits next cycle; any input handshaking in the flush cycle is discarded; data registers keep their values.
REQ-029 SHALL, without PIPE_MULT_FLUSH_EN, have no flush port; ops complete only via drain or reset.

Structure
REQ-030 SHALL place mul_func_t and the MUL_* encodings in shared package mult_pkg.
REQ-031 SHALL implement one sub-module pipe_mult_stage (partial product, shift, valid/stall register), instantiated NUM_STAGE times via generate.

Verification (XLEN=32, NUM_STAGE=4)
REQ-032 SHALL cover: MUL 7 x 6 accepted at cycle 0 -> out_valid at cycle 4, result 0x0000002A, tag echoed.
REQ-033 SHALL cover: rs1=rs2=0xFFFFFFFF -> MULH 0x00000000, MULHU 0xFFFFFFFE, MULHSU 0xFFFFFFFF, MUL 0x00000001.
REQ-034 SHALL cover: MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU same -> 0x40000000.
REQ-035 SHALL cover: 8 back-to-back ops with tags 0..7, out_ready low cycles 3-7 -> in_ready falls when all stages are full, outputs stay stable, all 8 results in tag order.
REQ-036 SHALL cover: reset asserted with 3 ops in flight -> next cycle out_valid=0, busy=0, in_ready=1; no stale result emerges.
REQ-037 SHALL cover (PIPE_MULT_FLUSH_EN): flush with 4 ops in flight plus one accepted in the same cycle -> zero outputs; a new op after the flush returns the correct result 4 cycles later.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared multiplier definitions: function encodings and operand-extension helpers.
package mult_pkg;

    typedef enum logic [1:0] {
        MUL_MUL    = 2'd0,
        MUL_MULH   = 2'd1,
        MUL_MULHSU = 2'd2,
        MUL_MULHU  = 2'd3
    } mul_func_t;

    function automatic logic rs1_is_signed(input mul_func_t f);
        return (f == MUL_MULH) || (f == MUL_MULHSU);
    endfunction

    function automatic logic rs2_is_signed(input mul_func_t f);
        return (f == MUL_MULH);
    endfunction

    function automatic logic want_high_half(input mul_func_t f);
        return (f != MUL_MUL);
    endfunction

endpackage

// File: rtl/pipe_mult_stage.sv
// One multiplier pipeline stage: adds one NUM_BITS-wide multiplier digit times the
// shifted multiplicand into the running product, with an elastic valid/stall register.
module pipe_mult_stage
    import mult_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_BITS = 16,
    parameter int TAG_W    = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_kill,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_next_ready,
    input  mul_func_t          i_func,
    input  logic [TAG_W-1:0]   i_tag,
    input  logic [2*XLEN-1:0]  i_mcand,
    input  logic [2*XLEN-1:0]  i_mplier,
    input  logic [2*XLEN-1:0]  i_prod,
    output logic               o_valid,
    output mul_func_t          o_func,
    output logic [TAG_W-1:0]   o_tag,
    output logic [2*XLEN-1:0]  o_mcand,
    output logic [2*XLEN-1:0]  o_mplier,
    output logic [2*XLEN-1:0]  o_prod
);

    localparam int PW = 2 * XLEN;

    logic              r_valid;
    mul_func_t         r_func;
    logic [TAG_W-1:0]  r_tag;
    logic [PW-1:0]     r_mcand;
    logic [PW-1:0]     r_mplier;
    logic [PW-1:0]     r_prod;
    logic [PW-1:0]     w_partial;
    logic              w_load;

    // The digit is zero-extended to full width so the product wraps modulo 2^PW.
    assign w_partial = PW'(i_mplier[NUM_BITS-1:0]) * i_mcand;

    // A stage can take new data when it is empty or its content moves on this cycle.
    assign o_ready = !r_valid || i_next_ready;
    assign w_load  = o_ready && i_valid && !i_kill;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_func   <= MUL_MUL;
            r_tag    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
        end else begin
            if (i_kill) begin
                r_valid <= 1'b0;
            end else if (o_ready) begin
                r_valid <= i_valid;
            end
            if (w_load) begin
                r_func   <= i_func;
                r_tag    <= i_tag;
                r_mcand  <= i_mcand << NUM_BITS;
                r_mplier <= i_mplier >> NUM_BITS;
                r_prod   <= i_prod + w_partial;
            end
        end
    end

    assign o_valid  = r_valid;
    assign o_func   = r_func;
    assign o_tag    = r_tag;
    assign o_mcand  = r_mcand;
    assign o_mplier = r_mplier;
    assign o_prod   = r_prod;

endmodule

// File: rtl/pipe_mult.sv
// Elastic NUM_STAGE-deep radix-2^NUM_BITS multiplier (MUL/MULH/MULHSU/MULHU) with tag pass-through.
// Optional flush port enabled by defining PIPE_MULT_FLUSH_EN.
module pipe_mult
    import mult_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_STAGE = 4,
    parameter int TAG_W     = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  mul_func_t         func,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  logic [TAG_W-1:0]  in_tag,
`ifdef PIPE_MULT_FLUSH_EN
    input  logic              flush,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    localparam int PW       = 2 * XLEN;
    localparam int NUM_BITS = PW / NUM_STAGE;

    generate
        if ((PW % NUM_STAGE) != 0) begin : g_bad_cfg
            $error("pipe_mult: 2*XLEN must be divisible by NUM_STAGE");
        end
    endgenerate

    logic              w_kill;
    logic [PW-1:0]     w_in_mcand;
    logic [PW-1:0]     w_in_mplier;
    logic              w_busy;
    logic              w_unused;

    logic              w_valid  [NUM_STAGE];
    logic              w_ready  [NUM_STAGE];
    mul_func_t         w_func   [NUM_STAGE];
    logic [TAG_W-1:0]  w_tag    [NUM_STAGE];
    logic [PW-1:0]     w_mcand  [NUM_STAGE];
    logic [PW-1:0]     w_mplier [NUM_STAGE];
    logic [PW-1:0]     w_prod   [NUM_STAGE];

`ifdef PIPE_MULT_FLUSH_EN
    assign w_kill = flush;
`else
    assign w_kill = 1'b0;
`endif

    assign w_in_mcand  = rs1_is_signed(func) ? {{XLEN{rs1[XLEN-1]}}, rs1} : {{XLEN{1'b0}}, rs1};
    assign w_in_mplier = rs2_is_signed(func) ? {{XLEN{rs2[XLEN-1]}}, rs2} : {{XLEN{1'b0}}, rs2};

    generate
        for (genvar gi = 0; gi < NUM_STAGE; gi++) begin : g_stage
            logic              w_up_valid;
            logic              w_down_ready;
            mul_func_t         w_up_func;
            logic [TAG_W-1:0]  w_up_tag;
            logic [PW-1:0]     w_up_mcand;
            logic [PW-1:0]     w_up_mplier;
            logic [PW-1:0]     w_up_prod;

            if (gi == 0) begin : g_first
                assign w_up_valid  = in_valid;
                assign w_up_func   = func;
                assign w_up_tag    = in_tag;
                assign w_up_mcand  = w_in_mcand;
                assign w_up_mplier = w_in_mplier;
                assign w_up_prod   = '0;
            end else begin : g_chain
                assign w_up_valid  = w_valid[gi-1];
                assign w_up_func   = w_func[gi-1];
                assign w_up_tag    = w_tag[gi-1];
                assign w_up_mcand  = w_mcand[gi-1];
                assign w_up_mplier = w_mplier[gi-1];
                assign w_up_prod   = w_prod[gi-1];
            end

            if (gi == NUM_STAGE - 1) begin : g_last
                assign w_down_ready = out_ready;
            end else begin : g_mid
                assign w_down_ready = w_ready[gi+1];
            end

            pipe_mult_stage #(
                .XLEN     (XLEN),
                .NUM_BITS (NUM_BITS),
                .TAG_W    (TAG_W)
            ) u_stage (
                .clock        (clock),
                .reset        (reset),
                .i_kill       (w_kill),
                .i_valid      (w_up_valid),
                .o_ready      (w_ready[gi]),
                .i_next_ready (w_down_ready),
                .i_func       (w_up_func),
                .i_tag        (w_up_tag),
                .i_mcand      (w_up_mcand),
                .i_mplier     (w_up_mplier),
                .i_prod       (w_up_prod),
                .o_valid      (w_valid[gi]),
                .o_func       (w_func[gi]),
                .o_tag        (w_tag[gi]),
                .o_mcand      (w_mcand[gi]),
                .o_mplier     (w_mplier[gi]),
                .o_prod       (w_prod[gi])
            );
        end
    endgenerate

    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < NUM_STAGE; i++) begin
            w_busy = w_busy | w_valid[i];
        end
    end

    // The last stage's leftover multiplicand/multiplier are fully consumed by then.
    assign w_unused = ^{w_mcand[NUM_STAGE-1], w_mplier[NUM_STAGE-1]};

    assign in_ready  = w_ready[0];
    assign out_valid = w_valid[NUM_STAGE-1];
    assign out_tag   = w_tag[NUM_STAGE-1];
    assign result    = want_high_half(w_func[NUM_STAGE-1]) ? w_prod[NUM_STAGE-1][PW-1:XLEN]
                                                           : w_prod[NUM_STAGE-1][XLEN-1:0];
    assign busy      = w_busy;

endmodule
